// File: rtl/amber48_pkg.sv
// Shared amber48 types: trap causes, execute/writeback records and memory-stage FSM states.
// TRAP_BUS_ERR is only produced when AMBER48_MEM_BUS_ERR_EN is defined.
package amber48_pkg;

    localparam int XLEN = 48;
    localparam int RD_W = 4;

    typedef enum logic [2:0] {
        TRAP_NONE       = 3'd0,
        TRAP_ILLEGAL    = 3'd1,
        TRAP_MISALIGNED = 3'd2,
        TRAP_ECALL      = 3'd3,
        TRAP_BUS_ERR    = 3'd4
    } trap_cause_e;

    typedef struct packed {
        logic              valid;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   store_data;
        logic              writeback_en;
        logic              load;
        logic              store;
        logic              trap;
        trap_cause_e       trap_cause;
    } amber48_execute_out_s;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic              en;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   data;
        logic              trap;
        trap_cause_e       trap_cause;
    } amber48_writeback_s;

    // Trapped ops never reach the bus, whatever their load/store flags say.
    function automatic logic is_mem_op(input amber48_execute_out_s op);
        return (op.load || op.store) && !op.trap;
    endfunction

endpackage

// File: rtl/amber48_mem_stage.sv
// amber48 memory stage: single-outstanding load/store bus master with a registered writeback record.
// Optional AMBER48_MEM_BUS_ERR_EN adds dmem_err_i, turning bus errors into TRAP_BUS_ERR traps.
module amber48_mem_stage
    import amber48_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  amber48_execute_out_s ex_i,
    output logic                 ex_ready_o,
    input  logic                 flush_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
`ifdef AMBER48_MEM_BUS_ERR_EN
    input  logic                 dmem_err_i,
`endif
    output logic                 wb_valid_o,
    output logic                 wb_en_o,
    output logic [RD_W-1:0]      wb_rd_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic                 wb_trap_o,
    output trap_cause_e          wb_trap_cause_o,
    output mem_state_e           state_o
);

    // Handshake: ex_i is taken on a cycle where ex_i.valid && ex_ready_o && !flush_i.
    // The dmem bus holds req/addr/we/wdata stable from the request until dmem_gnt_i.

    mem_state_e         state;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic               we_q;
    logic [RD_W-1:0]    rd_q;
    logic               wb_en_q;
    amber48_writeback_s wb_q;
    logic               accept;
    logic               bus_err;

    assign accept = ex_i.valid && (state == IDLE) && !flush_i;

`ifdef AMBER48_MEM_BUS_ERR_EN
    assign bus_err = dmem_err_i;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            wb_q.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem_op(ex_i)) begin
                            wb_q.valid      <= 1'b1;
                            wb_q.en         <= ex_i.writeback_en && !ex_i.trap;
                            wb_q.rd         <= ex_i.rd;
                            wb_q.data       <= ex_i.result;
                            wb_q.trap       <= ex_i.trap;
                            wb_q.trap_cause <= ex_i.trap ? ex_i.trap_cause : TRAP_NONE;
                        end else begin
                            addr_q  <= ex_i.result;
                            wdata_q <= ex_i.store_data;
                            we_q    <= ex_i.store;
                            rd_q    <= ex_i.rd;
                            wb_en_q <= ex_i.writeback_en;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        // A granted load still owes one rvalid, which DRAIN swallows.
                        state <= (dmem_gnt_i && !we_q) ? DRAIN : IDLE;
                    end else if (dmem_gnt_i) begin
                        if (we_q) begin
                            wb_q.valid      <= 1'b1;
                            wb_q.en         <= 1'b0;
                            wb_q.rd         <= rd_q;
                            wb_q.trap       <= bus_err;
                            wb_q.trap_cause <= bus_err ? TRAP_BUS_ERR : TRAP_NONE;
                            state           <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        if (!flush_i) begin
                            wb_q.valid      <= 1'b1;
                            wb_q.en         <= wb_en_q && !bus_err;
                            wb_q.rd         <= rd_q;
                            wb_q.data       <= dmem_rdata_i;
                            wb_q.trap       <= bus_err;
                            wb_q.trap_cause <= bus_err ? TRAP_BUS_ERR : TRAP_NONE;
                        end
                        state <= IDLE;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dmem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ex_ready_o      = (state == IDLE);
    assign dmem_req_o      = (state == REQ);
    assign dmem_we_o       = we_q;
    assign dmem_addr_o     = addr_q;
    assign dmem_wdata_o    = wdata_q;
    assign wb_valid_o      = wb_q.valid;
    assign wb_en_o         = wb_q.en;
    assign wb_rd_o         = wb_q.rd;
    assign wb_data_o       = wb_q.data;
    assign wb_trap_o       = wb_q.trap;
    assign wb_trap_cause_o = wb_q.trap_cause;
    assign state_o         = state;

endmodule

// File: tb/tb_amber48_mem_stage.sv
// Bench for amber48_mem_stage: directed protocol/flush/reset cases plus random ops checked against
// a transaction-level memory model. Bus-error cases are added when AMBER48_MEM_BUS_ERR_EN is defined.
module tb_amber48_mem_stage;
    import amber48_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    amber48_execute_out_s ex_i;
    logic                 ex_ready_o;
    logic                 flush_i;
    logic                 dmem_req_o;
    logic                 dmem_we_o;
    logic [XLEN-1:0]      dmem_addr_o;
    logic [XLEN-1:0]      dmem_wdata_o;
    logic                 dmem_gnt_i;
    logic                 dmem_rvalid_i;
    logic [XLEN-1:0]      dmem_rdata_i;
    logic                 dmem_err_i;
    logic                 wb_valid_o;
    logic                 wb_en_o;
    logic [RD_W-1:0]      wb_rd_o;
    logic [XLEN-1:0]      wb_data_o;
    logic                 wb_trap_o;
    trap_cause_e          wb_trap_cause_o;
    mem_state_e           state_o;

    amber48_mem_stage dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ex_i            (ex_i),
        .ex_ready_o      (ex_ready_o),
        .flush_i         (flush_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
`ifdef AMBER48_MEM_BUS_ERR_EN
        .dmem_err_i      (dmem_err_i),
`endif
        .wb_valid_o      (wb_valid_o),
        .wb_en_o         (wb_en_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .wb_trap_o       (wb_trap_o),
        .wb_trap_cause_o (wb_trap_cause_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] mem_model [logic [XLEN-1:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] mem_read(input logic [XLEN-1:0] a);
        if (!mem_model.exists(a)) mem_model[a] = {a[23:0] ^ 24'hC3A5F0, ~a[23:0]};
        return mem_model[a];
    endfunction

    function automatic logic [XLEN-1:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[XLEN-1:0];
    endfunction

    // Inputs change and outputs are sampled at the falling edge; the DUT acts on the rising edge.
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic check_wb(input string tag, input logic [RD_W-1:0] rd, input logic [XLEN-1:0] data,
                            input logic en, input logic trap, input trap_cause_e cause, input logic chk_data);
        check({tag, "_valid"}, wb_valid_o, 1'b1);
        check({tag, "_rd"}, wb_rd_o, rd);
        if (chk_data) check({tag, "_data"}, wb_data_o, data);
        check({tag, "_en"}, wb_en_o, en);
        check({tag, "_trap"}, wb_trap_o, trap);
        check({tag, "_cause"}, wb_trap_cause_o, cause);
    endtask

    // Drives one op through the stage with the given grant and rvalid delays (no flush).
    task automatic run_op(input amber48_execute_out_s op, input int gnt_dly, input int rv_dly);
        logic            mem_op;
        logic [XLEN-1:0] exp_data;
        mem_op = (op.load || op.store) && !op.trap;
        check("ready_at_issue", ex_ready_o, 1'b1);
        ex_i = op;
        ex_i.valid = 1'b1;
        step();
        ex_i = '0;
        if (!mem_op) begin
            check("nomem_req", dmem_req_o, 1'b0);
            check_wb("pass", op.rd, op.result, op.writeback_en && !op.trap, op.trap,
                     op.trap ? op.trap_cause : TRAP_NONE, 1'b1);
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            check("req", dmem_req_o, 1'b1);
            check("addr", dmem_addr_o, op.result);
            check("we", dmem_we_o, op.store);
            if (op.store) check("wdata", dmem_wdata_o, op.store_data);
            check("busy_req", ex_ready_o, 1'b0);
            check("nowb_req", wb_valid_o, 1'b0);
            dmem_gnt_i = (i == gnt_dly);
            step();
        end
        dmem_gnt_i = 1'b0;
        if (op.store) begin
            mem_model[op.result] = op.store_data;
            check_wb("store", op.rd, '0, 1'b0, 1'b0, TRAP_NONE, 1'b0);
            return;
        end
        exp_data = mem_read(op.result);
        for (int j = 1; j <= rv_dly; j++) begin
            check("req_drop", dmem_req_o, 1'b0);
            check("busy_wait", ex_ready_o, 1'b0);
            check("nowb_wait", wb_valid_o, 1'b0);
            dmem_rvalid_i = (j == rv_dly);
            dmem_rdata_i  = (j == rv_dly) ? exp_data : rand48();
            step();
        end
        dmem_rvalid_i = 1'b0;
        check_wb("load", op.rd, exp_data, op.writeback_en, 1'b0, TRAP_NONE, 1'b1);
    endtask

    // One empty cycle with a stray rvalid, which must be ignored.
    task automatic idle_cycle();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rand48();
        step();
        dmem_rvalid_i = 1'b0;
        check("idle_nowb", wb_valid_o, 1'b0);
        check("idle_ready", ex_ready_o, 1'b1);
    endtask

    function automatic amber48_execute_out_s make_op(input int kind);
        amber48_execute_out_s op;
        op = '0;
        op.rd           = RD_W'($urandom_range(0, 15));
        op.result       = (kind == 0) ? rand48() : XLEN'($urandom_range(0, 7) * 8);
        op.store_data   = rand48();
        op.writeback_en = 1'($urandom_range(0, 1));
        op.trap_cause   = trap_cause_e'($urandom_range(0, 3));
        op.load         = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
        op.store        = (kind == 2) || (kind == 3 && !op.load);
        op.trap         = (kind == 3);
        if (kind == 3) op.trap_cause = trap_cause_e'($urandom_range(1, 3));
        return op;
    endfunction

    task automatic issue_mem(input logic [XLEN-1:0] addr, input logic is_store, input logic [RD_W-1:0] rd);
        ex_i              = '0;
        ex_i.valid        = 1'b1;
        ex_i.rd           = rd;
        ex_i.result       = addr;
        ex_i.store_data   = 48'h5A5A;
        ex_i.writeback_en = !is_store;
        ex_i.load         = !is_store;
        ex_i.store        = is_store;
        step();
        ex_i = '0;
    endtask

    amber48_execute_out_s op;

    initial begin
        rst_ni        = 1'b0;
        ex_i          = '0;
        flush_i       = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        dmem_err_i    = 1'b0;
        step();
        step();
        check("rst_state", state_o, IDLE);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_wb_valid", wb_valid_o, 1'b0);
        check("rst_wb_data", wb_data_o, '0);
        check("rst_cause", wb_trap_cause_o, TRAP_NONE);
        rst_ni = 1'b1;
        step();

        // Plain ALU op.
        op = '0;
        op.result = 48'h000000001234;
        op.rd = 4'd3;
        op.writeback_en = 1'b1;
        run_op(op, 0, 0);
        idle_cycle();

        // Load at 0x40: grant after 2 waiting cycles, rvalid 3 cycles later.
        mem_model[48'h40] = 48'hABCDEF012345;
        op = '0;
        op.result = 48'h40;
        op.rd = 4'd7;
        op.writeback_en = 1'b1;
        op.load = 1'b1;
        run_op(op, 2, 3);

        // Store 0x5A5A to 0x80, immediate grant, then read it back.
        op = '0;
        op.result = 48'h80;
        op.store_data = 48'h5A5A;
        op.rd = 4'd2;
        op.store = 1'b1;
        run_op(op, 0, 0);
        op.store = 1'b0;
        op.load = 1'b1;
        op.writeback_en = 1'b1;
        run_op(op, 1, 1);

        // Trapped load never reaches the bus.
        op = '0;
        op.result = 48'h100;
        op.rd = 4'd9;
        op.writeback_en = 1'b1;
        op.load = 1'b1;
        op.trap = 1'b1;
        op.trap_cause = TRAP_ILLEGAL;
        run_op(op, 0, 0);
        idle_cycle();

        // Back-to-back ALU ops, one per cycle.
        for (int k = 0; k < 4; k++) run_op(make_op(0), 0, 0);
        idle_cycle();

        // Flush in IDLE: op not accepted, no writeback.
        ex_i = make_op(0);
        ex_i.valid = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        ex_i = '0;
        check("flush_idle_nowb", wb_valid_o, 1'b0);
        check("flush_idle_ready", ex_ready_o, 1'b1);

        // Flush in REQ without grant: request dropped.
        issue_mem(48'h18, 1'b0, 4'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_req_drop", dmem_req_o, 1'b0);
        check("flush_req_ready", ex_ready_o, 1'b1);
        check("flush_req_nowb", wb_valid_o, 1'b0);

        // Flush with a store grant: store commits, no writeback.
        issue_mem(48'h20, 1'b1, 4'd4);
        dmem_gnt_i = 1'b1;
        flush_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        flush_i = 1'b0;
        mem_model[48'h20] = 48'h5A5A;
        check("flush_st_nowb", wb_valid_o, 1'b0);
        check("flush_st_ready", ex_ready_o, 1'b1);

        // Load granted, flush in WAIT, rvalid two cycles later is drained.
        issue_mem(48'h28, 1'b0, 4'd5);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("drain_state", state_o, DRAIN);
        check("drain_busy", ex_ready_o, 1'b0);
        step();
        check("drain_nowb0", wb_valid_o, 1'b0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = rand48();
        step();
        dmem_rvalid_i = 1'b0;
        check("drain_nowb", wb_valid_o, 1'b0);
        check("drain_ready", ex_ready_o, 1'b1);

        // Flush coincident with rvalid suppresses the writeback.
        issue_mem(48'h30, 1'b0, 4'd6);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        step();
        dmem_rvalid_i = 1'b1;
        flush_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        flush_i = 1'b0;
        check("flush_rv_nowb", wb_valid_o, 1'b0);
        check("flush_rv_ready", ex_ready_o, 1'b1);

`ifdef AMBER48_MEM_BUS_ERR_EN
        issue_mem(48'h38, 1'b0, 4'd8);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_err_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        dmem_err_i = 1'b0;
        check_wb("berr_ld", 4'd8, '0, 1'b0, 1'b1, TRAP_BUS_ERR, 1'b0);
        issue_mem(48'h40, 1'b1, 4'd9);
        dmem_gnt_i = 1'b1;
        dmem_err_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        dmem_err_i = 1'b0;
        check_wb("berr_st", 4'd9, '0, 1'b0, 1'b1, TRAP_BUS_ERR, 1'b0);
`endif

        // Random mix of ALU, load, store and trapped ops.
        for (int k = 0; k < 60; k++) begin
            run_op(make_op(int'($urandom_range(0, 3))), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Asynchronous reset while a request is pending.
        issue_mem(48'h48, 1'b0, 4'd10);
        check("pre_rst_req", dmem_req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_req", dmem_req_o, 1'b0);
        check("arst_state", state_o, IDLE);
        check("arst_wb_valid", wb_valid_o, 1'b0);
        check("arst_wb_en", wb_en_o, 1'b0);
        check("arst_wb_rd", wb_rd_o, '0);
        check("arst_wb_data", wb_data_o, '0);
        check("arst_wb_trap", wb_trap_o, 1'b0);
        check("arst_cause", wb_trap_cause_o, TRAP_NONE);
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_ready", ex_ready_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amber48_mem_stage.md
Name: amber48_mem_stage

Overview:
Memory stage directly downstream of the amber48 execute stage. It consumes one amber48_execute_out_s per handshake and issues loads and stores on a single-outstanding data-memory request/grant/rvalid bus. It produces a registered writeback record (rd, data, enable, trap) for the register file and trap unit. Non-memory ops and trapped ops pass through with one-cycle latency.

Parameters:
XLEN, 48 (from amber48_pkg), data and address width
RD_W, 4, destination register index width (matches execute_out rd field)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
ex_i  in  struct  amber48_execute_out_s: valid, rd, result (address or ALU value), store_data, writeback_en, load, store, trap, trap_cause
ex_ready_o  out  1  stage can accept ex_i this cycle
flush_i  in  1  kill the in-flight op; no writeback is produced
dmem_req_o  out  1  memory request valid
dmem_we_o  out  1  1 = store
dmem_addr_o  out  XLEN  word address (ex_i.result)
dmem_wdata_o  out  XLEN  store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  XLEN  load data
wb_valid_o  out  1  writeback record valid (single-cycle pulse per op)
wb_en_o  out  1  write rd
wb_rd_o  out  RD_W  destination register
wb_data_o  out  XLEN  writeback value
wb_trap_o  out  1  op trapped
wb_trap_cause_o  out  trap_cause_e  cause; TRAP_NONE when wb_trap_o=0

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; all outputs 0; wb_trap_cause_o = TRAP_NONE; dmem_req_o = 0 immediately.
- FSM states: IDLE, REQ, WAIT, DRAIN. ex_ready_o = (state == IDLE). Acceptance = ex_i.valid && ex_ready_o && !flush_i.
- IDLE, accept non-memory op or any op with ex_i.trap: register the op; wb_valid_o = 1 next cycle; wb_data_o = result; wb_en_o = writeback_en && !trap. Stay in IDLE, so back-to-back accepts give 1 op/cycle.
- IDLE, accept load/store without trap: latch address, wdata, rd and we into holding registers; go to REQ. dmem_* is driven only from these registers (no combinational path from ex_i).
- REQ: dmem_req_o = 1 with stable addr/we/wdata until dmem_gnt_i. On a store gnt: wb_valid_o = 1 next cycle with wb_en_o = 0; go to IDLE. On a load gnt: go to WAIT.
- WAIT: on dmem_rvalid_i, wb_valid_o = 1 next cycle with wb_data_o = dmem_rdata_i and wb_en_o = writeback_en; go to IDLE. rvalid never arrives in the gnt cycle. rvalid in any other state is ignored.
- Minimum latency from accept cycle N: ALU op at N+1; store with gnt at N+1 gives wb at N+2; load with gnt at N+1 and rvalid at N+2 gives wb at N+3.
- flush_i in IDLE: the op presented this cycle is not accepted, and any wb_valid_o due next cycle is suppressed.
- flush_i in REQ without gnt: drop the request (dmem_req_o = 0 next cycle), go to IDLE, no wb.
- flush_i in REQ with gnt, or in WAIT: a store is already committed and produces no wb; a load goes to DRAIN, or to WAIT-equivalent DRAIN if rvalid has not arrived. DRAIN consumes exactly one rvalid, discards it, then goes to IDLE. A flush in the rvalid cycle suppresses that wb.
- ex_ready_o = 0 in REQ, WAIT and DRAIN.
- All wb_* outputs are registered. wb_valid_o deasserts after one cycle; data fields hold their last value.

Optional Feature:
AMBER48_MEM_BUS_ERR_EN: adds input dmem_err_i (1 bit, qualified with dmem_rvalid_i for loads, or with dmem_gnt_i for stores). When dmem_err_i is high, wb_trap_o = 1, wb_trap_cause_o = TRAP_BUS_ERR, wb_en_o = 0. Without the macro, the port is absent and memory ops never trap in this stage.

Decomposition:
- amber48_pkg gains: TRAP_BUS_ERR in trap_cause_e; mem_state_e {IDLE, REQ, WAIT, DRAIN}; amber48_writeback_s (valid, en, rd, data, trap, trap_cause).
- Output bundle is driven as amber48_writeback_s internally.
- No sub-module; a single FSM plus holding registers.

Test Plan:
- ALU op: result=0x000000001234, rd=3, writeback_en=1 -> next cycle wb_valid_o=1, wb_rd_o=3, wb_data_o=0x000000001234.
- Load addr 0x40, gnt delayed 2 cycles, rvalid 3 cycles later with 0xABCDEF012345 -> dmem_addr_o stable through REQ, ex_ready_o=0 throughout, wb_data_o=0xABCDEF012345 one cycle after rvalid.
- Store addr 0x80, data 0x5A5A, immediate gnt -> dmem_we_o=1, wb_valid_o=1 with wb_en_o=0 one cycle after gnt.
- Load granted, flush_i in WAIT, rvalid 2 cycles later -> DRAIN, no wb_valid_o, ex_ready_o=1 the cycle after rvalid.
- ex_i.trap=1 with trap_cause=TRAP_ILLEGAL and load=1 -> no dmem_req_o; wb_trap_o=1, wb_en_o=0, cause TRAP_ILLEGAL.
- rst_ni asserted in REQ -> dmem_req_o=0 immediately, state IDLE, all wb outputs 0. With AMBER48_MEM_BUS_ERR_EN: rvalid with dmem_err_i=1 -> wb_trap_cause_o=TRAP_BUS_ERR.
